// File: rtl/freq_meter_pkg.sv
// freq_meter_pkg
//   Shared definitions for the frequency meter: gate FSM state encoding,
//   default parameter values and the counter saturation helper.
//   No ports; imported by freq_meter and edge_sync.
package freq_meter_pkg;

  localparam int DEF_GATE_CYCLES = 100_000_000;  // 1 s at 100 MHz
  localparam int DEF_CNT_W       = 32;
  localparam int DEF_SYNC_STAGES = 2;

  typedef enum logic {
    IDLE = 1'b0,
    GATE = 1'b1
  } state_t;

  // All-ones value for a counter of the given width (width <= 63).
  function automatic logic [63:0] cnt_max(input int width);
    return (64'd1 << width) - 64'd1;
  endfunction

endpackage

// File: rtl/edge_sync.sv
// edge_sync
//   Brings an asynchronous input into the clk domain and produces a
//   registered one-cycle pulse for each rising edge seen after the
//   synchronizer. A rising edge on async_in shows up on edge_pulse
//   SYNC_STAGES+1 clk edges later.
// Ports
//   clk        in   system clock
//   rst        in   synchronous active-high reset
//   async_in   in   asynchronous signal
//   edge_pulse out  one-cycle pulse per synchronized rising edge
module edge_sync
  import freq_meter_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic edge_pulse
);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   sync_q;
  logic                   sync_qq;

  assign sync_q = sync_r[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_r     <= '0;
      sync_qq    <= 1'b0;
      edge_pulse <= 1'b0;
    end else begin
      sync_r     <= {sync_r[SYNC_STAGES-2:0], async_in};
      sync_qq    <= sync_q;
      edge_pulse <= sync_q & ~sync_qq;
    end
  end

endmodule

// File: rtl/freq_meter.sv
// freq_meter
//   Counts rising edges of sig_in over back-to-back gate windows of
//   GATE_CYCLES clk cycles and reports each completed window as a held
//   count plus a one-cycle valid strobe.
//
//   state | meaning
//   ------+----------------------------------------------------------
//   IDLE  | not measuring; counters held at zero, busy low
//   GATE  | window in progress; gate_cnt runs 0..GATE_CYCLES-1
//
// Ports
//   clk          in   system clock
//   rst          in   synchronous active-high reset
//   en           in   1 = measure continuously, 0 = idle
//   sig_in       in   asynchronous signal under test
//   freq_count   out  edges counted in the last completed window (held)
//   meas_valid   out  one-cycle pulse when freq_count/ovf update
//   ovf          out  last completed window saturated the edge counter
//   busy         out  a window is in progress
//   period_count out  clk cycles between consecutive edges  (FREQ_METER_PERIOD_EN)
//   period_valid out  one-cycle pulse per period report       (FREQ_METER_PERIOD_EN)
//
// Build option: define FREQ_METER_PERIOD_EN to add the period measurement.
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int GATE_CYCLES = DEF_GATE_CYCLES,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sig_in,
  output logic [CNT_W-1:0] freq_count,
  output logic             meas_valid,
  output logic             ovf,
  output logic             busy
`ifdef FREQ_METER_PERIOD_EN
  ,
  output logic [CNT_W-1:0] period_count,
  output logic             period_valid
`endif
);

  localparam int               GATE_W    = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  EDGE_MAX  = CNT_W'(cnt_max(CNT_W));

  state_t             state_q;
  state_t             state_d;
  logic               edge_pulse;
  logic [GATE_W-1:0]  gate_cnt;
  logic [CNT_W-1:0]   edge_cnt;
  logic               sat_q;
  logic               edge_at_max;
  logic [CNT_W-1:0]   edge_cnt_nxt;
  logic               sat_nxt;

  edge_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_edge_sync (
    .clk        (clk),
    .rst        (rst),
    .async_in   (sig_in),
    .edge_pulse (edge_pulse)
  );

  // ---------------- gate FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (en)  state_d = GATE;
      GATE:    if (!en) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == GATE);
  end

  // ---------------- edge counting ----------------
  // Count including the current cycle's pulse; this is also the value
  // reported at the end of a window, so a pulse on the last window cycle
  // is included.
  always_comb begin
    edge_at_max  = (edge_cnt == EDGE_MAX);
    edge_cnt_nxt = edge_cnt;
    sat_nxt      = sat_q;
    if (edge_pulse) begin
      if (edge_at_max) sat_nxt = 1'b1;
      else             edge_cnt_nxt = edge_cnt + CNT_W'(1);
    end
  end

  // Window end restarts counters in the same step the result is latched,
  // so the following cycle is already gate_cnt=0 of the next window.
  always_ff @(posedge clk) begin
    if (rst) begin
      gate_cnt   <= '0;
      edge_cnt   <= '0;
      sat_q      <= 1'b0;
      freq_count <= '0;
      ovf        <= 1'b0;
      meas_valid <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      if (state_q == GATE && en) begin
        if (gate_cnt == GATE_LAST) begin
          gate_cnt   <= '0;
          edge_cnt   <= '0;
          sat_q      <= 1'b0;
          freq_count <= edge_cnt_nxt;
          ovf        <= sat_nxt;
          meas_valid <= 1'b1;
        end else begin
          gate_cnt <= gate_cnt + GATE_W'(1);
          edge_cnt <= edge_cnt_nxt;
          sat_q    <= sat_nxt;
        end
      end else begin
        // Idle or aborting: partial window is discarded, results hold.
        gate_cnt <= '0;
        edge_cnt <= '0;
        sat_q    <= 1'b0;
      end
    end
  end

`ifdef FREQ_METER_PERIOD_EN
  // ---------------- period measurement ----------------
  // per_cnt holds clk cycles elapsed since the last edge pulse; it is
  // loaded with 1 on a pulse so that the next pulse sees the full spacing.
  logic [CNT_W-1:0] per_cnt;
  logic             per_armed;

  always_ff @(posedge clk) begin
    if (rst) begin
      per_cnt      <= '0;
      per_armed    <= 1'b0;
      period_count <= '0;
      period_valid <= 1'b0;
    end else begin
      period_valid <= 1'b0;
      if (state_q != GATE) begin
        per_cnt   <= '0;
        per_armed <= 1'b0;
      end else if (edge_pulse) begin
        per_cnt   <= CNT_W'(1);
        per_armed <= 1'b1;
        if (per_armed) begin
          period_count <= per_cnt;
          period_valid <= 1'b1;
        end
      end else if (per_cnt != EDGE_MAX) begin
        per_cnt <= per_cnt + CNT_W'(1);
      end
    end
  end
`endif

endmodule
